cgp_stream_sum_compare: RTL and testbench

- Sequential, parametrised successor to the combinational two-group sum-and-compare TNN node.
- Each beat carries LANES positive and LANES negative unsigned operands. Per-group sums accumulate over a variable number of beats until a last marker. A biased greater-than / greater-or-equal decision is then issued on a valid/ready output handshake.
- Sits between the feature streamer and the vote/argmax stage of the TNN datapath.

---
 rtl/cgp_stream_sum_compare.sv | 197 +++++++++++++++++++
 tb/tb_cgp_stream_sum_compare.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cgp_stream_sum_compare.sv
// Streaming two-group sum-and-compare node: per-beat lane sums, saturating per-group
// accumulation over a sample, and a biased >/>= decision offered on a valid/ready output.
module cgp_stream_sum_compare #(
   parameter int IN_W  = 3,
   parameter int LANES = 3,
   parameter int ACC_W = 7,
   parameter int BIAS  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [LANES*IN_W-1:0] in_pos,
   input  logic [LANES*IN_W-1:0] in_neg,
   input  logic                  in_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  cmp_ge,
   output logic                  out_gt,
   output logic                  out_ovf,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam int SUM_W = IN_W + $clog2(LANES);
   localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
   localparam int CMP_W = ACC_W + 2;
   localparam logic [ACC_W-1:0]        ACC_MAX = {ACC_W{1'b1}};
   localparam logic signed [CMP_W-1:0] BIAS_C  = CMP_W'(BIAS);

   typedef enum logic [1:0] {
      ST_ACCUM = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   function automatic logic [SUM_W-1:0] lane_sum(input logic [LANES*IN_W-1:0] v);
      logic [SUM_W-1:0] s;
      s = {SUM_W{1'b0}};
      for (int k = 0; k < LANES; k++) begin
         s = s + SUM_W'(v[k*IN_W +: IN_W]);
      end
      return s;
   endfunction

   // Result is {clamped, value}; the sum is formed one bit wider than either operand.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                              input logic [SUM_W-1:0] b);
      logic [EXT_W-1:0] t;
      t = EXT_W'(a) + EXT_W'(b);
      if (t > EXT_W'(ACC_MAX)) begin
         return {1'b1, ACC_MAX};
      end else begin
         return {1'b0, t[ACC_W-1:0]};
      end
   endfunction

   state_t                   state_r, state_nxt_s;
   logic [SUM_W-1:0]         pos_sum_r, neg_sum_r;
   logic                     s1_last_r, s1_v_r;
   logic [ACC_W-1:0]         acc_pos_r, acc_neg_r;
   logic                     ovf_r, first_r, cmp_ge_r;
   logic [ACC_W:0]           pos_upd_s, neg_upd_s;
   logic [ACC_W-1:0]         acc_pos_nxt_s, acc_neg_nxt_s;
   logic                     ovf_nxt_s;
   logic signed [CMP_W-1:0]  cmp_pos_s, cmp_neg_s;
   logic                     gt_s, accept_s, handshake_s;

   assign accept_s    = in_valid & in_ready;
   assign handshake_s = out_valid & out_ready;

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_ACCUM;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_ACCUM: begin
            if (accept_s && in_last) begin
               state_nxt_s = ST_FLUSH;
            end else begin
               state_nxt_s = ST_ACCUM;
            end
         end
         ST_FLUSH: state_nxt_s = ST_HOLD;
         ST_HOLD: begin
            if (handshake_s) begin
               state_nxt_s = ST_ACCUM;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: state_nxt_s = ST_ACCUM;
      endcase
   end

   // FSM outputs; in_ready is masked by rst so nothing is taken during reset
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_r)
         ST_ACCUM: in_ready  = ~rst;
         ST_FLUSH: in_ready  = 1'b0;
         ST_HOLD:  out_valid = 1'b1;
         default: begin
            in_ready  = 1'b0;
            out_valid = 1'b0;
         end
      endcase
   end

   // Stage 1: exact per-beat lane sums
   always_ff @(posedge clk) begin
      if (rst) begin
         pos_sum_r <= {SUM_W{1'b0}};
         neg_sum_r <= {SUM_W{1'b0}};
         s1_last_r <= 1'b0;
         s1_v_r    <= 1'b0;
      end else if (accept_s) begin
         pos_sum_r <= lane_sum(in_pos);
         neg_sum_r <= lane_sum(in_neg);
         s1_last_r <= in_last;
         s1_v_r    <= 1'b1;
      end else begin
         s1_v_r    <= 1'b0;
      end
   end

   // Stage 2 next values, also consumed by the decision on the last beat
   always_comb begin
      pos_upd_s = sat_add(acc_pos_r, pos_sum_r);
      neg_upd_s = sat_add(acc_neg_r, neg_sum_r);
      if (s1_v_r) begin
         acc_pos_nxt_s = pos_upd_s[ACC_W-1:0];
         acc_neg_nxt_s = neg_upd_s[ACC_W-1:0];
         ovf_nxt_s     = ovf_r | pos_upd_s[ACC_W] | neg_upd_s[ACC_W];
      end else begin
         acc_pos_nxt_s = acc_pos_r;
         acc_neg_nxt_s = acc_neg_r;
         ovf_nxt_s     = ovf_r;
      end
   end

   // Biased signed compare of the final sums
   always_comb begin
      cmp_pos_s = $signed({2'b00, acc_pos_nxt_s}) + BIAS_C;
      cmp_neg_s = $signed({2'b00, acc_neg_nxt_s});
      if (cmp_ge_r) begin
         gt_s = (cmp_pos_s >= cmp_neg_s);
      end else begin
         gt_s = (cmp_pos_s > cmp_neg_s);
      end
   end

   // Stage 2 accumulators and sticky overflow, cleared when the result is taken
   always_ff @(posedge clk) begin
      if (rst || handshake_s) begin
         acc_pos_r <= {ACC_W{1'b0}};
         acc_neg_r <= {ACC_W{1'b0}};
         ovf_r     <= 1'b0;
      end else begin
         acc_pos_r <= acc_pos_nxt_s;
         acc_neg_r <= acc_neg_nxt_s;
         ovf_r     <= ovf_nxt_s;
      end
   end

   // Compare mode is latched from the first beat of each sample only
   always_ff @(posedge clk) begin
      if (rst || handshake_s) begin
         first_r <= 1'b1;
         if (rst) begin
            cmp_ge_r <= 1'b0;
         end
      end else if (accept_s && first_r) begin
         first_r  <= 1'b0;
         cmp_ge_r <= cmp_ge;
      end
   end

   // Decision register, loaded while the last beat drains through stage 2
   always_ff @(posedge clk) begin
      if (rst) begin
         out_gt  <= 1'b0;
         out_ovf <= 1'b0;
      end else if (s1_v_r && s1_last_r) begin
         out_gt  <= gt_s;
         out_ovf <= ovf_nxt_s;
      end
   end

endmodule

// File: tb/tb_cgp_stream_sum_compare.sv
// Randomised self-checking bench: three parameter variants share one stimulus stream
// and are compared against a sample-level arithmetic model.
module tb_cgp_stream_sum_compare;

   logic       clk = 1'b0;
   logic       rst, in_last, in_valid, cmp_ge, out_ready;
   logic [8:0] in_pos, in_neg;
   logic [2:0] rdy, ovld, ogt, oovf;

   int checks = 0;
   int errors = 0;

   logic [8:0] bp [16];
   logic [8:0] bn [16];
   logic       timed_out;
   logic [2:0] fl_rdy, fl_vld, hd_rdy, post_vld, post_rdy;
   int         lat;

   always #5 clk = ~clk;

   cgp_stream_sum_compare #(.IN_W(3), .LANES(3), .ACC_W(7), .BIAS(0)) u_dut_def (
      .clk(clk), .rst(rst), .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
      .in_valid(in_valid), .in_ready(rdy[0]), .cmp_ge(cmp_ge), .out_gt(ogt[0]),
      .out_ovf(oovf[0]), .out_valid(ovld[0]), .out_ready(out_ready));

   cgp_stream_sum_compare #(.IN_W(3), .LANES(3), .ACC_W(7), .BIAS(-1)) u_dut_bias (
      .clk(clk), .rst(rst), .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
      .in_valid(in_valid), .in_ready(rdy[1]), .cmp_ge(cmp_ge), .out_gt(ogt[1]),
      .out_ovf(oovf[1]), .out_valid(ovld[1]), .out_ready(out_ready));

   cgp_stream_sum_compare #(.IN_W(3), .LANES(3), .ACC_W(5), .BIAS(0)) u_dut_sat (
      .clk(clk), .rst(rst), .in_pos(in_pos), .in_neg(in_neg), .in_last(in_last),
      .in_valid(in_valid), .in_ready(rdy[2]), .cmp_ge(cmp_ge), .out_gt(ogt[2]),
      .out_ovf(oovf[2]), .out_valid(ovld[2]), .out_ready(out_ready));

   function automatic int dut_acc_w(input int d);
      return (d == 2) ? 5 : 7;
   endfunction

   function automatic int dut_bias(input int d);
      return (d == 1) ? -1 : 0;
   endfunction

   function automatic logic [8:0] pack3(input int a, input int b, input int c);
      return {3'(c), 3'(b), 3'(a)};
   endfunction

   function automatic int lane_total(input logic [8:0] v);
      return int'(v[2:0]) + int'(v[5:3]) + int'(v[8:6]);
   endfunction

   function automatic int stream_total(input int n, input logic use_pos);
      int t;
      t = 0;
      for (int b = 0; b < n; b++) t += lane_total(use_pos ? bp[b] : bn[b]);
      return t;
   endfunction

   // Reference: a saturating running sum equals min(true total, max); it clamped iff total > max
   function automatic logic [2:0] exp_gt(input int pt, input int nt, input logic ge);
      logic [2:0] r;
      int mx, p, n;
      for (int d = 0; d < 3; d++) begin
         mx = (1 << dut_acc_w(d)) - 1;
         p  = ((pt > mx) ? mx : pt) + dut_bias(d);
         n  = (nt > mx) ? mx : nt;
         r[d] = ge ? (p >= n) : (p > n);
      end
      return r;
   endfunction

   function automatic logic [2:0] exp_ovf(input int pt, input int nt);
      logic [2:0] r;
      int mx;
      for (int d = 0; d < 3; d++) begin
         mx = (1 << dut_acc_w(d)) - 1;
         r[d] = (pt > mx) || (nt > mx);
      end
      return r;
   endfunction

   // Drives beats bp/bn[0..n-1]; cmp_ge is only meaningful on beat 0, later beats get noise
   task automatic send_sample(input int n, input logic ge);
      int waitc;
      timed_out = 1'b0;
      for (int b = 0; b < n; b++) begin
         if (!timed_out) begin
            in_valid = 1'b1;
            in_pos   = bp[b];
            in_neg   = bn[b];
            in_last  = (b == n - 1);
            cmp_ge   = (b == 0) ? ge : 1'($urandom_range(0, 1));
            waitc    = 0;
            while (rdy[0] !== 1'b1 && waitc < 20) begin
               @(posedge clk); #1;
               waitc++;
            end
            if (rdy[0] !== 1'b1) timed_out = 1'b1;
            else begin
               @(posedge clk); #1;
            end
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_pos   = 9'($urandom);
      in_neg   = 9'($urandom);
      fl_rdy   = rdy;
      fl_vld   = ovld;
      lat      = 0;
      while (ovld[0] !== 1'b1 && lat < 8) begin
         @(posedge clk); #1;
         lat++;
      end
      hd_rdy = rdy;
   endtask

   task automatic do_handshake();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      post_vld  = ovld;
      post_rdy  = rdy;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; cmp_ge = 1'b0;
      in_pos = 9'd0; in_neg = 9'd0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({rdy, ovld, ogt, oovf} !== 12'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b gt=%b ovf=%b expected all 0", rdy, ovld, ogt, oovf);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (rdy !== 3'b111) begin
         errors++;
         $display("FAIL reset_release_ready: got %b expected 111", rdy);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_single_beat();
      bp[0] = pack3(7, 7, 7); bn[0] = pack3(1, 2, 3);
      send_sample(1, 1'b0);
      checks++;
      if ({timed_out, lat[3:0], fl_vld, fl_rdy, hd_rdy} !== {1'b0, 4'd1, 9'd0}) begin
         errors++;
         $display("FAIL single_timing: got to=%b lat=%0d flush_vld=%b flush_rdy=%b hold_rdy=%b expected 0 1 000 000 000",
                  timed_out, lat, fl_vld, fl_rdy, hd_rdy);
      end
      checks++;
      if (ogt !== exp_gt(21, 6, 1'b0) || oovf !== exp_ovf(21, 6)) begin
         errors++;
         $display("FAIL single_result: got gt=%b ovf=%b expected gt=%b ovf=%b", ogt, oovf, exp_gt(21, 6, 1'b0), exp_ovf(21, 6));
      end
      do_handshake();
      checks++;
      if ({post_vld, post_rdy} !== {3'b000, 3'b111}) begin
         errors++;
         $display("FAIL single_handshake: got vld=%b rdy=%b expected 000 111", post_vld, post_rdy);
      end
   endtask

   task automatic test_tie();
      for (int g = 0; g < 2; g++) begin
         bp[0] = pack3(2, 2, 2); bn[0] = pack3(3, 3, 0);
         send_sample(1, 1'(g));
         checks++;
         if (timed_out || ogt !== exp_gt(6, 6, 1'(g)) || oovf !== 3'b000) begin
            errors++;
            $display("FAIL tie_ge%0d: got gt=%b ovf=%b to=%b expected gt=%b ovf=000", g, ogt, oovf, timed_out, exp_gt(6, 6, 1'(g)));
         end
         do_handshake();
      end
   endtask

   task automatic test_multi_beat();
      bp[0] = pack3(1, 0, 0); bp[1] = pack3(0, 1, 0); bp[2] = pack3(0, 0, 1);
      bn[0] = pack3(0, 0, 0); bn[1] = pack3(0, 0, 0); bn[2] = pack3(2, 0, 0);
      send_sample(3, 1'b0);
      checks++;
      if ({timed_out, lat[3:0], fl_vld, fl_rdy, hd_rdy} !== {1'b0, 4'd1, 9'd0}) begin
         errors++;
         $display("FAIL multi_timing: got to=%b lat=%0d flush_vld=%b flush_rdy=%b hold_rdy=%b expected 0 1 000 000 000",
                  timed_out, lat, fl_vld, fl_rdy, hd_rdy);
      end
      checks++;
      if (ogt !== exp_gt(3, 2, 1'b0) || oovf !== 3'b000) begin
         errors++;
         $display("FAIL multi_result: got gt=%b ovf=%b expected gt=%b ovf=000", ogt, oovf, exp_gt(3, 2, 1'b0));
      end
      do_handshake();
   endtask

   task automatic test_backpressure();
      int pt, nt;
      logic ge;
      for (int b = 0; b < 2; b++) begin
         bp[b] = 9'($urandom); bn[b] = 9'($urandom);
      end
      ge = 1'($urandom_range(0, 1));
      pt = stream_total(2, 1'b1); nt = stream_total(2, 1'b0);
      send_sample(2, ge);
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0] ? 1'b0 : 1'b1;
         in_last  = 1'b1;
         in_pos   = 9'h1FF;
         in_neg   = 9'($urandom);
         @(posedge clk); #1;
         checks++;
         if ({ovld, rdy, ogt, oovf} !== {3'b111, 3'b000, exp_gt(pt, nt, ge), exp_ovf(pt, nt)}) begin
            errors++;
            $display("FAIL backpressure_hold%0d: got vld=%b rdy=%b gt=%b ovf=%b expected 111 000 %b %b",
                     c, ovld, rdy, ogt, oovf, exp_gt(pt, nt, ge), exp_ovf(pt, nt));
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
      do_handshake();
      checks++;
      if ({post_vld, post_rdy} !== {3'b000, 3'b111}) begin
         errors++;
         $display("FAIL backpressure_release: got vld=%b rdy=%b expected 000 111", post_vld, post_rdy);
      end
      bp[0] = pack3(0, 1, 0); bn[0] = pack3(0, 0, 2);
      send_sample(1, 1'b1);
      checks++;
      if (timed_out || ogt !== exp_gt(1, 2, 1'b1) || oovf !== 3'b000) begin
         errors++;
         $display("FAIL backpressure_next: got gt=%b ovf=%b to=%b expected gt=%b ovf=000", ogt, oovf, timed_out, exp_gt(1, 2, 1'b1));
      end
      do_handshake();
   endtask

   task automatic test_saturation();
      bp[0] = pack3(7, 7, 7); bp[1] = pack3(7, 7, 7);
      bn[0] = pack3(0, 0, 1); bn[1] = pack3(0, 0, 1);
      send_sample(2, 1'b0);
      checks++;
      if (ogt !== exp_gt(42, 2, 1'b0) || oovf !== exp_ovf(42, 2)) begin
         errors++;
         $display("FAIL sat_pos: got gt=%b ovf=%b expected gt=%b ovf=%b", ogt, oovf, exp_gt(42, 2, 1'b0), exp_ovf(42, 2));
      end
      do_handshake();
      for (int b = 0; b < 8; b++) begin
         bp[b] = pack3(7, 7, 7); bn[b] = pack3(7, 7, 7);
      end
      send_sample(8, 1'b1);
      checks++;
      if (timed_out || ogt !== exp_gt(168, 168, 1'b1) || oovf !== exp_ovf(168, 168)) begin
         errors++;
         $display("FAIL sat_both: got gt=%b ovf=%b expected gt=%b ovf=%b", ogt, oovf, exp_gt(168, 168, 1'b1), exp_ovf(168, 168));
      end
      do_handshake();
   endtask

   task automatic test_mid_reset();
      // Leave a non-zero decision in place so the reset clear is observable
      bp[0] = pack3(7, 7, 7); bn[0] = pack3(0, 0, 0);
      send_sample(1, 1'b1);
      out_ready = 1'b0;
      for (int b = 0; b < 2; b++) begin
         in_valid = 1'b1; in_last = 1'b0; in_pos = pack3(7, 7, 7); in_neg = 9'd0; cmp_ge = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if ({rdy, ovld, ogt, oovf} !== 12'd0) begin
         errors++;
         $display("FAIL midreset_outputs: got rdy=%b vld=%b gt=%b ovf=%b expected all 0", rdy, ovld, ogt, oovf);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (rdy !== 3'b111) begin
         errors++;
         $display("FAIL midreset_ready: got %b expected 111", rdy);
      end
      @(posedge clk); #1;
      bp[0] = pack3(0, 0, 0); bn[0] = pack3(1, 0, 0);
      send_sample(1, 1'b0);
      checks++;
      if (timed_out || ogt !== exp_gt(0, 1, 1'b0) || oovf !== 3'b000) begin
         errors++;
         $display("FAIL midreset_fresh: got gt=%b ovf=%b to=%b expected gt=%b ovf=000", ogt, oovf, timed_out, exp_gt(0, 1, 1'b0));
      end
      do_handshake();
   endtask

   task automatic test_all_zero();
      for (int g = 0; g < 2; g++) begin
         bp[0] = 9'd0; bn[0] = 9'd0;
         send_sample(1, 1'(g));
         checks++;
         if (timed_out || ogt !== exp_gt(0, 0, 1'(g)) || oovf !== 3'b000) begin
            errors++;
            $display("FAIL zero_ge%0d: got gt=%b ovf=%b expected gt=%b ovf=000", g, ogt, oovf, exp_gt(0, 0, 1'(g)));
         end
         do_handshake();
      end
   endtask

   task automatic test_back_to_back();
      int n, pt, nt;
      logic ge;
      for (int i = 0; i < 40; i++) begin
         n = $urandom_range(1, 10);
         for (int b = 0; b < n; b++) begin
            bp[b] = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom);
            bn[b] = ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom);
         end
         ge = 1'($urandom_range(0, 1));
         pt = stream_total(n, 1'b1); nt = stream_total(n, 1'b0);
         send_sample(n, ge);
         checks++;
         if ({timed_out, lat[3:0], fl_vld, fl_rdy, hd_rdy} !== {1'b0, 4'd1, 9'd0}) begin
            errors++;
            $display("FAIL rand%0d_timing: got to=%b lat=%0d flush_vld=%b flush_rdy=%b hold_rdy=%b expected 0 1 000 000 000",
                     i, timed_out, lat, fl_vld, fl_rdy, hd_rdy);
         end
         checks++;
         if (ogt !== exp_gt(pt, nt, ge) || oovf !== exp_ovf(pt, nt)) begin
            errors++;
            $display("FAIL rand%0d_result: beats=%0d pos=%0d neg=%0d ge=%b got gt=%b ovf=%b expected gt=%b ovf=%b",
                     i, n, pt, nt, ge, ogt, oovf, exp_gt(pt, nt, ge), exp_ovf(pt, nt));
         end
         do_handshake();
         checks++;
         if ({post_vld, post_rdy} !== {3'b000, 3'b111}) begin
            errors++;
            $display("FAIL rand%0d_handshake: got vld=%b rdy=%b expected 000 111", i, post_vld, post_rdy);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_tie();
      test_multi_beat();
      test_backpressure();
      test_saturation();
      test_mid_reset();
      test_all_zero();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
